// File: rtl/traffic_pkg.sv
// Shared state encodings, lamp codes and sequencing helper
// for the two-road intersection phase controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    M_G  = 3'd1,
    M_Y  = 3'd2,
    AR1  = 3'd3,
    S_G  = 3'd4,
    S_Y  = 3'd5,
    AR2  = 3'd6
  } state_t;

  localparam logic [2:0] LT_R = 3'b100;
  localparam logic [2:0] LT_Y = 3'b010;
  localparam logic [2:0] LT_G = 3'b001;

  function automatic state_t next_state(
    input state_t s
  );
    case (s)
      IDLE:    next_state = M_G;
      M_G:     next_state = M_Y;
      M_Y:     next_state = AR1;
      AR1:     next_state = S_G;
      S_G:     next_state = S_Y;
      S_Y:     next_state = AR2;
      AR2:     next_state = M_G;
      default: next_state = IDLE;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Seconds countdown for the current phase; a load wins
// over a tick decrement, expire flags the last second.
module phase_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic [CNT_W-1:0] cnt,
  output logic             expire
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (tick && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = tick && (cnt == CNT_W'(1));

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Phase FSM, pedestrian request latches and registered
// lamp/walk/countdown outputs for a two-road intersection.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int G_T   = 10,
  parameter int Y_T   = 3,
  parameter int AR_T  = 2,
  parameter int MIN_G = 3,
  parameter int CNT_W = 5
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             sys_clk_1s,
  input  logic             ped_req_main,
  input  logic             ped_req_side,
  output logic [2:0]       light_main,
  output logic [2:0]       light_side,
  output logic             walk_main,
  output logic             walk_side,
  output logic [CNT_W-1:0] light_t,
  output logic [2:0]       phase
);

  state_t           state;
  state_t           nxt;
  logic             req_main;
  logic             req_side;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] cnt;
  logic             expire;
  logic             shorten;

  function automatic logic [CNT_W-1:0] dur(
    input state_t s
  );
    case (s)
      M_G, S_G: dur = CNT_W'(G_T);
      M_Y, S_Y: dur = CNT_W'(Y_T);
      AR1, AR2: dur = CNT_W'(AR_T);
      default:  dur = '0;
    endcase
  endfunction

  phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk      (sys_clk),
    .rst      (sys_rst_n),
    .load     (load),
    .load_val (load_val),
    .tick     (sys_clk_1s),
    .cnt      (cnt),
    .expire   (expire)
  );

  // Only the green conflicting with a waiting crossing is cut short
  assign shorten =
    ((state == M_G && req_main) ||
     (state == S_G && req_side)) &&
    (cnt > CNT_W'(MIN_G));

  always_comb begin
    nxt      = state;
    load     = 1'b0;
    load_val = cnt;
    if (sys_clk_1s) begin
      if (state == IDLE || expire) begin
        nxt      = next_state(state);
        load     = 1'b1;
        load_val = dur(next_state(state));
      end else if (shorten) begin
        load     = 1'b1;
        load_val = CNT_W'(MIN_G);
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      state      <= IDLE;
      req_main   <= 1'b0;
      req_side   <= 1'b0;
      light_main <= LT_R;
      light_side <= LT_R;
      walk_main  <= 1'b0;
      walk_side  <= 1'b0;
      light_t    <= '0;
      phase      <= IDLE;
    end else begin
      state <= nxt;

      if (nxt == S_G && state != S_G) begin
        req_main <= 1'b0;
      end else if (ped_req_main && state != S_G) begin
        req_main <= 1'b1;
      end

      if (nxt == M_G && state != M_G) begin
        req_side <= 1'b0;
      end else if (ped_req_side && state != M_G) begin
        req_side <= 1'b1;
      end

      case (state)
        M_G: begin
          light_main <= LT_G;
          light_side <= LT_R;
        end
        M_Y: begin
          light_main <= LT_Y;
          light_side <= LT_R;
        end
        S_G: begin
          light_main <= LT_R;
          light_side <= LT_G;
        end
        S_Y: begin
          light_main <= LT_R;
          light_side <= LT_Y;
        end
        default: begin
          light_main <= LT_R;
          light_side <= LT_R;
        end
      endcase

      walk_side <= (state == M_G);
      walk_main <= (state == S_G);
      light_t   <= cnt;
      phase     <= state;
    end
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler with a
// cycle-level reference model and literal spot checks.
module tb_traffic_phase_scheduler;

  localparam int G_T   = 10;
  localparam int Y_T   = 3;
  localparam int AR_T  = 2;
  localparam int MIN_G = 3;
  localparam int CNT_W = 5;
  localparam int R = 4;
  localparam int Y = 2;
  localparam int G = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             tick = 1'b0;
  logic             pm = 1'b0;
  logic             ps = 1'b0;
  logic [2:0]       lm;
  logic [2:0]       ls;
  logic             wm;
  logic             wsd;
  logic [CNT_W-1:0] lt;
  logic [2:0]       ph;

  int checks = 0;
  int errors = 0;

  traffic_phase_scheduler #(
    .G_T(G_T), .Y_T(Y_T), .AR_T(AR_T),
    .MIN_G(MIN_G), .CNT_W(CNT_W)
  ) dut (
    .sys_clk      (clk),
    .sys_rst_n    (rst),
    .sys_clk_1s   (tick),
    .ped_req_main (pm),
    .ped_req_side (ps),
    .light_main   (lm),
    .light_side   (ls),
    .walk_main    (wm),
    .walk_side    (wsd),
    .light_t      (lt),
    .phase        (ph)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // Reference: phases 1..6 cycle, 0 is the idle start
  int m_st = 0, m_cnt = 0, e_st = 0, e_cnt = 0;
  int n_st, n_cnt;
  bit m_rm = 0, m_rs = 0;

  function automatic int dur_of(input int s);
    if (s == 1 || s == 4) return G_T;
    if (s == 2 || s == 5) return Y_T;
    return AR_T;
  endfunction

  function automatic int lamp_m(input int s);
    return (s == 1) ? G : (s == 2) ? Y : R;
  endfunction

  function automatic int lamp_s(input int s);
    return (s == 4) ? G : (s == 5) ? Y : R;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st = 0; m_cnt = 0; m_rm = 0; m_rs = 0;
      e_st = 0; e_cnt = 0;
    end else begin
      e_st = m_st;
      e_cnt = m_cnt;
      n_st = m_st;
      n_cnt = m_cnt;
      if (tick) begin
        if (m_st == 0 || m_cnt == 1) begin
          n_st = (m_st == 0) ? 1 : (m_st % 6) + 1;
          n_cnt = dur_of(n_st);
        end else if (((m_st == 1 && m_rm) ||
                      (m_st == 4 && m_rs)) &&
                     m_cnt > MIN_G) begin
          n_cnt = MIN_G;
        end else begin
          n_cnt = m_cnt - 1;
        end
      end
      if (m_st == 4 || n_st == 4) m_rm = 0;
      else if (pm) m_rm = 1;
      if (m_st == 1 || n_st == 1) m_rs = 0;
      else if (ps) m_rs = 1;
      m_st = n_st;
      m_cnt = n_cnt;
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("m_phase", int'(ph), e_st);
      chk("m_light_t", int'(lt), e_cnt);
      chk("m_light_main", int'(lm), lamp_m(e_st));
      chk("m_light_side", int'(ls), lamp_s(e_st));
      chk("m_walk_main", int'(wm), int'(e_st == 4));
      chk("m_walk_side", int'(wsd), int'(e_st == 1));
      chk("m_no_conflict",
          int'(lm != 3'b100 && ls != 3'b100), 0);
    end
  end

  task automatic do_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse(input bit a, input bit b);
    @(negedge clk) begin pm = a; ps = b; end
    @(negedge clk) begin pm = 1'b0; ps = 1'b0; end
  endtask

  task automatic expect_pt(input string name, input int p,
                           input int t);
    chk({name, "_phase"}, int'(ph), p);
    chk({name, "_t"}, int'(lt), t);
  endtask

  task automatic advance_to(input int p, input int t);
    int n = 0;
    while (!(int'(ph) == p && int'(lt) == t) && n < 100) begin
      do_tick();
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL advance_to: phase %0d t %0d not reached, at %0d/%0d",
               p, t, ph, lt);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_lm", int'(lm), R);
    chk("rst_ls", int'(ls), R);
    expect_pt("rst", 0, 0);
    chk("rst_ws", int'(wsd), 0);

    do_tick();
    chk("t1_lm", int'(lm), G);
    chk("t1_ws", int'(wsd), 1);
    expect_pt("t1", 1, 10);

    for (int i = 2; i <= 41; i++) begin
      do_tick();
      if (i == 10) expect_pt("run10", 1, 1);
      if (i == 11) expect_pt("run11", 2, 3);
      if (i == 14) expect_pt("run14", 3, 2);
      if (i == 16) expect_pt("run16", 4, 10);
      if (i == 26) expect_pt("run26", 5, 3);
      if (i == 29) expect_pt("run29", 6, 2);
      if (i == 31) expect_pt("run31", 1, 10);
    end
    expect_pt("run41", 2, 3);

    advance_to(1, 8);
    pulse(1, 0);
    do_tick(); expect_pt("sh_a", 1, 3);
    do_tick(); expect_pt("sh_b", 1, 2);
    do_tick(); expect_pt("sh_c", 1, 1);
    do_tick(); expect_pt("sh_d", 2, 3);
    advance_to(4, 10);
    do_tick(); expect_pt("sh_sg", 4, 9);
    advance_to(1, 10);
    do_tick(); expect_pt("sh_clr", 1, 9);

    advance_to(1, 2);
    pulse(1, 0);
    do_tick(); expect_pt("late_a", 1, 1);
    do_tick(); expect_pt("late_b", 2, 3);

    advance_to(1, 7);
    pulse(0, 1);
    advance_to(4, 10);
    do_tick(); expect_pt("ign_sg", 4, 9);
    advance_to(6, 2);
    pulse(0, 1);
    do_tick(); expect_pt("ar2_a", 6, 1);
    do_tick(); expect_pt("ar2_b", 1, 10);
    do_tick(); expect_pt("ar2_c", 1, 9);
    advance_to(4, 10);
    do_tick(); expect_pt("ar2_sg", 4, 9);

    advance_to(1, 9);
    pulse(1, 1);
    do_tick(); expect_pt("both_mg", 1, 3);
    advance_to(2, 3);
    pulse(1, 1);
    advance_to(4, 10);
    do_tick(); expect_pt("both_sg", 4, 3);
    advance_to(1, 10);
    do_tick(); expect_pt("both_mg2", 1, 9);

    advance_to(5, 2);
    pulse(1, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_lm", int'(lm), R);
    chk("mid_ls", int'(ls), R);
    expect_pt("mid", 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    expect_pt("post_rst", 0, 0);
    do_tick(); expect_pt("post_a", 1, 10);
    do_tick(); expect_pt("post_b", 1, 9);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
